// File: rtl/idu_pkg.sv
// Shared decode constants for the IDU ALU/branch decode stage: opcodes, funct7 values
// and the ALU/branch operation codes seen by the EXU.
package idu_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_BEQ  = 4'd10;
  localparam logic [3:0] ALU_BNE  = 4'd11;
  localparam logic [3:0] ALU_BLT  = 4'd12;
  localparam logic [3:0] ALU_BGE  = 4'd13;
  localparam logic [3:0] ALU_BLTU = 4'd14;
  localparam logic [3:0] ALU_BGEU = 4'd15;

endpackage

// File: rtl/idu_alu_dec_stage_if.sv
// Fetch-side valid/ready instruction channel and EXU-side decoded bundle channel.
interface idu_alu_dec_stage_if #(
  parameter int XLEN      = 32,
  parameter int OUT_WIDTH = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_inst;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out_alu_code;
  logic                 out_use_imm;
  logic                 out_is_branch;
  logic                 out_illegal;
  logic [4:0]           out_rd;
  logic [4:0]           out_rs1;
  logic [4:0]           out_rs2;
  logic [XLEN-1:0]      out_imm;

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_alu_code, out_use_imm, out_is_branch,
           out_illegal, out_rd, out_rs1, out_rs2, out_imm
  );

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_alu_code, out_use_imm, out_is_branch,
           out_illegal, out_rd, out_rs1, out_rs2, out_imm
  );
endinterface

// File: rtl/idu_alu_dec_table.sv
// Pure combinational RV32 R / OP-IMM / BRANCH decode into ALU code, operand flags,
// register indices and XLEN sign-extended immediate.
module idu_alu_dec_table
  import idu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int OUT_WIDTH     = 4,
  parameter bit ENABLE_IMM    = 1'b1,
  parameter bit ENABLE_BRANCH = 1'b1
) (
  input  logic [31:0]          inst,
  output logic [OUT_WIDTH-1:0] alu_code,
  output logic                 use_imm,
  output logic                 is_branch,
  output logic                 illegal,
  output logic [4:0]           rd,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [XLEN-1:0]      imm
);
  logic [6:0]      opc;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [3:0]      code;
  logic            use_imm_d;
  logic            is_branch_d;
  logic            ill;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_sh;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];
  assign rd  = inst[11:7];
  assign rs1 = inst[19:15];
  assign rs2 = inst[24:20];

  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_b  = {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  // Shift-immediates carry funct7 in the upper I-field; the EXU only wants the shamt.
  assign imm_sh = XLEN'(inst[24:20]);

  always_comb begin
    code        = ALU_ADD;
    use_imm_d   = 1'b0;
    is_branch_d = 1'b0;
    ill         = 1'b0;
    imm_d       = '0;
    case (opc)
      OPC_R: begin
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0:    code = ALU_ADD;
            3'd1:    code = ALU_SLL;
            3'd2:    code = ALU_SLT;
            3'd3:    code = ALU_SLTU;
            3'd4:    code = ALU_XOR;
            3'd5:    code = ALU_SRL;
            3'd6:    code = ALU_OR;
            default: code = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'd0) begin
          code = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'd5) begin
          code = ALU_SRA;
        end else begin
          ill = 1'b1;
        end
      end
      OPC_IMM: begin
        use_imm_d = 1'b1;
        imm_d     = imm_i;
        case (f3)
          3'd0: code = ALU_ADD;
          3'd2: code = ALU_SLT;
          3'd3: code = ALU_SLTU;
          3'd4: code = ALU_XOR;
          3'd6: code = ALU_OR;
          3'd7: code = ALU_AND;
          3'd1: begin
            code  = ALU_SLL;
            imm_d = imm_sh;
            ill   = (f7 != F7_BASE);
          end
          default: begin
            code  = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            imm_d = imm_sh;
            ill   = (f7 != F7_BASE) && (f7 != F7_ALT);
          end
        endcase
        if (!ENABLE_IMM) ill = 1'b1;
      end
      OPC_BRANCH: begin
        is_branch_d = 1'b1;
        imm_d       = imm_b;
        case (f3)
          3'd0:    code = ALU_BEQ;
          3'd1:    code = ALU_BNE;
          3'd4:    code = ALU_BLT;
          3'd5:    code = ALU_BGE;
          3'd6:    code = ALU_BLTU;
          3'd7:    code = ALU_BGEU;
          default: ill  = 1'b1;
        endcase
        if (!ENABLE_BRANCH) ill = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      code        = ALU_ADD;
      use_imm_d   = 1'b0;
      is_branch_d = 1'b0;
      imm_d       = '0;
    end
  end

  assign alu_code  = OUT_WIDTH'(code);
  assign use_imm   = use_imm_d;
  assign is_branch = is_branch_d;
  assign illegal   = ill;
  assign imm       = imm_d;
endmodule

// File: rtl/idu_alu_dec_stage.sv
// Registered ALU/branch decode stage between IFU and EXU: one-cycle valid/ready
// pipeline slot with flush and a saturating count of accepted illegal instructions.
module idu_alu_dec_stage
  import idu_pkg::*;
#(
  parameter int NR_KEY        = 16,
  parameter int XLEN          = 32,
  parameter bit ENABLE_IMM    = 1'b1,
  parameter bit ENABLE_BRANCH = 1'b1,
  parameter int ILL_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  idu_alu_dec_stage_if.slave   bus,
  output logic [ILL_CNT_W-1:0] ill_count
);
  localparam int OUT_WIDTH = $clog2(NR_KEY);
  localparam logic [ILL_CNT_W-1:0] CNT_MAX = '1;

  logic [OUT_WIDTH-1:0] dec_alu_code;
  logic                 dec_use_imm;
  logic                 dec_is_branch;
  logic                 dec_illegal;
  logic [4:0]           dec_rd;
  logic [4:0]           dec_rs1;
  logic [4:0]           dec_rs2;
  logic [XLEN-1:0]      dec_imm;
  logic                 accept;

  idu_alu_dec_table #(
    .XLEN          (XLEN),
    .OUT_WIDTH     (OUT_WIDTH),
    .ENABLE_IMM    (ENABLE_IMM),
    .ENABLE_BRANCH (ENABLE_BRANCH)
  ) u_table (
    .inst      (bus.in_inst),
    .alu_code  (dec_alu_code),
    .use_imm   (dec_use_imm),
    .is_branch (dec_is_branch),
    .illegal   (dec_illegal),
    .rd        (dec_rd),
    .rs1       (dec_rs1),
    .rs2       (dec_rs2),
    .imm       (dec_imm)
  );

  // Flush forces ready so fetch can be drained even when the EXU is stalled.
  assign bus.in_ready = !bus.out_valid || bus.out_ready || flush;
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  // Decode -> output register stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid     <= 1'b0;
      bus.out_alu_code  <= '0;
      bus.out_use_imm   <= 1'b0;
      bus.out_is_branch <= 1'b0;
      bus.out_illegal   <= 1'b0;
      bus.out_rd        <= '0;
      bus.out_rs1       <= '0;
      bus.out_rs2       <= '0;
      bus.out_imm       <= '0;
      ill_count         <= '0;
    end else begin
      if (accept) begin
        bus.out_valid     <= 1'b1;
        bus.out_alu_code  <= dec_alu_code;
        bus.out_use_imm   <= dec_use_imm;
        bus.out_is_branch <= dec_is_branch;
        bus.out_illegal   <= dec_illegal;
        bus.out_rd        <= dec_rd;
        bus.out_rs1       <= dec_rs1;
        bus.out_rs2       <= dec_rs2;
        bus.out_imm       <= dec_imm;
      end else if (flush || bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      if (accept && dec_illegal && ill_count != CNT_MAX) begin
        ill_count <= ill_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_idu_alu_dec_stage.sv
// Self-checking bench for idu_alu_dec_stage: directed scenarios plus randomized traffic
// against a table-driven reference of the decode rules and the one-slot handshake.
module tb_idu_alu_dec_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] ill_count;

  idu_alu_dec_stage_if #(.XLEN(32), .OUT_WIDTH(4)) bus ();

  idu_alu_dec_stage #(
    .NR_KEY        (16),
    .XLEN          (32),
    .ENABLE_IMM    (1'b1),
    .ENABLE_BRANCH (1'b1),
    .ILL_CNT_W     (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus.slave),
    .ill_count (ill_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          code;
    bit          use_imm;
    bit          is_br;
    bit          ill;
    logic [31:0] imm;
  } ref_t;

  int          n_chk = 0;
  int          n_err = 0;
  bit          m_valid;
  ref_t        m_dec;
  logic [31:0] m_inst;
  int          m_cnt;

  function automatic ref_t ref_dec(input logic [31:0] inst);
    int r_tab [8] = '{0, 5, 8, 9, 2, 6, 3, 4};
    int b_tab [8] = '{10, 11, -1, -1, 12, 13, 14, 15};
    ref_t r;
    int f3, f7, opc, i12, b13;
    opc = int'(inst[6:0]);
    f3  = int'(inst[14:12]);
    f7  = int'(inst[31:25]);
    i12 = int'(inst[31:20]);
    if (i12 >= 2048) i12 -= 4096;
    b13 = int'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    if (b13 >= 4096) b13 -= 8192;
    r = '{code: 0, use_imm: 0, is_br: 0, ill: 0, imm: 32'd0};
    if (opc == 'h33) begin
      if (f7 == 0)                  r.code = r_tab[f3];
      else if (f7 == 32 && f3 == 0) r.code = 1;
      else if (f7 == 32 && f3 == 5) r.code = 7;
      else                          r.ill = 1;
    end else if (opc == 'h13) begin
      r.use_imm = 1;
      if (f3 == 1 || f3 == 5) begin
        r.imm = 32'(int'(inst[24:20]));
        if (f3 == 1 && f7 == 0)       r.code = 5;
        else if (f3 == 5 && f7 == 0)  r.code = 6;
        else if (f3 == 5 && f7 == 32) r.code = 7;
        else                          r.ill = 1;
      end else begin
        r.code = r_tab[f3];
        r.imm  = 32'(i12);
      end
    end else if (opc == 'h63) begin
      r.is_br = 1;
      r.imm   = 32'(b13);
      if (b_tab[f3] < 0) r.ill = 1;
      else               r.code = b_tab[f3];
    end else begin
      r.ill = 1;
    end
    if (r.ill) r = '{code: 0, use_imm: 0, is_br: 0, ill: 1, imm: 32'd0};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("ill_count", 64'(ill_count), 64'(m_cnt));
    if (m_valid) begin
      chk("alu_code", 64'(bus.out_alu_code), 64'(m_dec.code));
      chk("flags", 64'({bus.out_use_imm, bus.out_is_branch, bus.out_illegal}),
          64'({m_dec.use_imm, m_dec.is_br, m_dec.ill}));
      chk("regs", 64'({bus.out_rd, bus.out_rs1, bus.out_rs2}),
          64'({m_inst[11:7], m_inst[19:15], m_inst[24:20]}));
      chk("imm", 64'(bus.out_imm), 64'(m_dec.imm));
    end
  endtask

  // Drives one cycle of inputs from a negedge, advances the model, checks at the next negedge.
  task automatic step(input bit vld, input logic [31:0] inst, input bit rdy, input bit fl);
    bit   exp_rdy, acc;
    ref_t d;
    bus.in_valid  = vld;
    bus.in_inst   = inst;
    bus.out_ready = rdy;
    flush         = fl;
    #1;
    exp_rdy = !m_valid || rdy || fl;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    acc = vld && exp_rdy && !fl;
    d   = ref_dec(inst);
    if (acc) begin
      m_valid = 1;
      m_inst  = inst;
      m_dec   = d;
      if (d.ill && m_cnt < 3) m_cnt++;
    end else if (fl || rdy) begin
      m_valid = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_bundle"}, 64'({bus.out_alu_code, bus.out_use_imm, bus.out_is_branch,
        bus.out_illegal, bus.out_rd, bus.out_rs1, bus.out_rs2}), 64'd0);
    chk({tag, "_imm"}, 64'(bus.out_imm), 64'd0);
    chk({tag, "_cnt"}, 64'(ill_count), 64'd0);
  endtask

  task automatic apply_reset();
    #2 rst = 1'b1;
    #1 check_zero("reset");
    m_valid = 0;
    m_cnt   = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 3);
    if (sel == 0)      r[6:0] = 7'b0110011;
    else if (sel == 1) r[6:0] = 7'b0010011;
    else if (sel == 2) r[6:0] = 7'b1100011;
    sel = $urandom_range(0, 3);
    if (sel == 0)      r[31:25] = 7'h00;
    else if (sel == 1) r[31:25] = 7'h20;
    return r;
  endfunction

  initial begin
    int e5 [6] = '{1, 2, 3, 3, 3, 3};
    rst           = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_inst   = '0;
    bus.out_ready = 1'b0;
    m_valid       = 0;
    m_cnt         = 0;
    m_inst        = '0;
    m_dec         = ref_dec(32'd0);
    apply_reset();

    step(1, 32'h002081B3, 1, 0);
    chk("t1_code", 64'(bus.out_alu_code), 64'd0);
    chk("t1_regs", 64'({bus.out_rd, bus.out_rs1, bus.out_rs2}), 64'({5'd3, 5'd1, 5'd2}));
    step(1, 32'h402081B3, 1, 0);
    chk("t2_sub", 64'(bus.out_alu_code), 64'd1);
    step(1, 32'h4030D093, 1, 0);
    chk("t2_srai", 64'({bus.out_alu_code, bus.out_use_imm}), 64'({4'd7, 1'b1}));
    chk("t2_imm", 64'(bus.out_imm), 64'd3);
    step(1, 32'h0020F463, 1, 0);
    chk("t3_bgeu", 64'({bus.out_alu_code, bus.out_is_branch}), 64'({4'd15, 1'b1}));
    chk("t3_imm", 64'(bus.out_imm), 64'd8);
    step(1, 32'h0020A463, 1, 0);
    chk("t3_ill", 64'({bus.out_illegal, ill_count}), 64'({1'b1, 2'd1}));

    for (int i = 0; i < 3; i++) step(1, 32'h00308133 + 32'(i << 7), 0, 0);
    step(1, 32'h402081B3, 1, 0);
    step(1, 32'h0020F463, 1, 0);
    step(1, 32'h00C10093, 1, 0);
    step(0, 32'h0, 1, 0);

    apply_reset();
    for (int i = 0; i < 6; i++) begin
      step(1, 32'hFFFFFFFF, 1, 0);
      chk("t5_cnt", 64'(ill_count), 64'(e5[i]));
    end

    apply_reset();
    step(1, 32'h002081B3, 0, 0);
    step(1, 32'hFFFFFFFF, 0, 1);
    chk("t6_flush", 64'({bus.out_valid, ill_count}), 64'd0);
    step(1, 32'h402081B3, 1, 0);
    step(1, 32'hFFFFFFFF, 0, 0);
    apply_reset();

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, rand_inst(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 19) == 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
